// File: rtl/atm_pin_entry.sv
// ---------------------------------------------------------------------------
// atm_pin_entry
//
// Keypad front-end for the ATM controller. Raw keypad strobes are debounced,
// a fixed-length BCD PIN is collected while a card is present, and the
// finished PIN is offered to the controller with a valid/ready handshake.
//
// Parameters
//   PIN_DIGITS      digits per PIN (1..7)
//   DEBOUNCE_CYCLES consecutive stable strobe samples needed to accept a key
//   TIMEOUT_CYCLES  inactivity limit in ENTRY (only with ATM_PIN_TIMEOUT_EN)
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous reset, active low
//   card_inserted  in   session active while high
//   key_strobe     in   raw keypad press, undebounced
//   key_code       in   0-9 digit, A clear, B cancel, C enter, others ignored
//   pin_ready      in   controller accepts the PIN
//   pin_out        out  BCD PIN, first digit in the top nibble
//   pin_valid      out  PIN complete and held stable
//   key_in         out  last accepted digit (display echo)
//   digit_count    out  number of digits held
//   entry_active   out  high while collecting digits
//   entry_error    out  one-cycle pulse on ENTER with too few digits
//   timeout_flag   out  inactivity timeout occurred (until card removal)
//
// Build option
//   ATM_PIN_TIMEOUT_EN  when defined, an inactivity down-counter runs in
//                       ENTRY and forces DONE on expiry. When undefined no
//                       counter exists and timeout_flag is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no session; waiting for card_inserted
// ENTRY | collecting digits, CLEAR/CANCEL/ENTER acted on
// HOLD  | PIN complete, pin_valid high until pin_ready accepts it
// DONE  | PIN handed off (or timed out); waiting for card removal
// ---------------------------------------------------------------------------
module atm_pin_entry #(
    parameter int PIN_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    card_inserted,
    input  logic                    key_strobe,
    input  logic [3:0]              key_code,
    input  logic                    pin_ready,
    output logic [4*PIN_DIGITS-1:0] pin_out,
    output logic                    pin_valid,
    output logic [3:0]              key_in,
    output logic [2:0]              digit_count,
    output logic                    entry_active,
    output logic                    entry_error,
    output logic                    timeout_flag
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ENTRY = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hB;
    localparam logic [3:0] KEY_ENTER  = 4'hC;

    localparam int              PW       = 4 * PIN_DIGITS;
    localparam logic [2:0]      CNT_FULL = 3'(PIN_DIGITS);
    localparam int              DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LOAD  = DB_W'(DEBOUNCE_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Debounce
    // r_db_rem counts down the samples still needed for the current run; the
    // key fires on the edge where the last needed sample arrives. r_db_held
    // blocks further acceptances until the strobe is seen low once, so a key
    // held across any state change is never taken twice.
    // -----------------------------------------------------------------------
    logic            r_db_run;
    logic [3:0]      r_db_code;
    logic [DB_W-1:0] r_db_rem;
    logic            r_db_held;
    logic            w_db_cont;
    logic            w_db_hit;
    logic            w_key_evt;

    assign w_db_cont = key_strobe && r_db_run && (key_code == r_db_code);
    assign w_db_hit  = key_strobe &&
                       (w_db_cont ? (r_db_rem == DB_W'(1)) : (DB_LOAD == '0));
    assign w_key_evt = w_db_hit && !r_db_held;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_db_run  <= 1'b0;
            r_db_code <= 4'd0;
            r_db_rem  <= '0;
            r_db_held <= 1'b0;
        end else if (!key_strobe) begin
            r_db_run  <= 1'b0;
            r_db_rem  <= '0;
            r_db_held <= 1'b0;
        end else begin
            r_db_run  <= 1'b1;
            r_db_code <= key_code;
            if (w_db_cont) begin
                if (r_db_rem != '0) begin
                    r_db_rem <= r_db_rem - DB_W'(1);
                end
            end else begin
                r_db_rem <= DB_LOAD;
            end
            if (w_key_evt) begin
                r_db_held <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Inactivity timeout
    // -----------------------------------------------------------------------
    logic r_state_is_entry;
    logic w_to_expire;
    logic [1:0] r_state;

    assign r_state_is_entry = (r_state == S_ENTRY);

`ifdef ATM_PIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;
    logic            w_to_reload;

    // An accepted key on the would-be expiry edge counts as activity.
    assign w_to_reload = ((r_state == S_IDLE) && card_inserted) ||
                         (r_state_is_entry && w_key_evt);
    assign w_to_expire = card_inserted && r_state_is_entry && !w_key_evt &&
                         (r_to_cnt == TO_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_to_reload) begin
                r_to_cnt <= TO_W'(TIMEOUT_CYCLES);
            end else if (r_state_is_entry && (r_to_cnt != '0)) begin
                r_to_cnt <= r_to_cnt - TO_W'(1);
            end

            if (!card_inserted) begin
                r_timeout <= 1'b0;
            end else if (w_to_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_flag = r_timeout;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
    assign w_to_expire  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Session FSM and PIN datapath
    // Card removal is checked first so it beats any key or timeout event
    // landing on the same edge.
    // -----------------------------------------------------------------------
    logic [PW-1:0] r_pin;
    logic [2:0]    r_cnt;
    logic [3:0]    r_key;
    logic          r_valid;
    logic          r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pin   <= '0;
            r_cnt   <= 3'd0;
            r_key   <= 4'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (!card_inserted) begin
                r_state <= S_IDLE;
                r_pin   <= '0;
                r_cnt   <= 3'd0;
                r_key   <= 4'd0;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ENTRY;
                        r_pin   <= '0;
                        r_cnt   <= 3'd0;
                    end
                    S_ENTRY: begin
                        if (w_to_expire) begin
                            r_state <= S_DONE;
                            r_pin   <= '0;
                            r_cnt   <= 3'd0;
                        end else if (w_key_evt) begin
                            if (key_code <= 4'd9) begin
                                if (r_cnt < CNT_FULL) begin
                                    r_pin <= (r_pin << 4) | PW'(key_code);
                                    r_cnt <= r_cnt + 3'd1;
                                    r_key <= key_code;
                                end
                            end else if (key_code == KEY_CLEAR) begin
                                if (r_cnt != 3'd0) begin
                                    r_pin <= r_pin >> 4;
                                    r_cnt <= r_cnt - 3'd1;
                                end
                            end else if (key_code == KEY_CANCEL) begin
                                r_pin <= '0;
                                r_cnt <= 3'd0;
                                r_key <= 4'd0;
                            end else if (key_code == KEY_ENTER) begin
                                if (r_cnt == CNT_FULL) begin
                                    r_state <= S_HOLD;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                        end
                    end
                    S_HOLD: begin
                        if (r_valid && pin_ready) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_pin   <= '0;
                            r_cnt   <= 3'd0;
                        end
                    end
                    default: begin
                        r_state <= S_DONE;
                    end
                endcase
            end
        end
    end

    assign pin_out      = r_pin;
    assign pin_valid    = r_valid;
    assign key_in       = r_key;
    assign digit_count  = r_cnt;
    assign entry_active = r_state_is_entry;
    assign entry_error  = r_err;

endmodule
